// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, opcodes and window-byte table for the SPI LCD sequencer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_SEND,
        ST_INIT_DELAY,
        ST_READY,
        ST_WIN_SEND,
        ST_PIX_WAIT,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int ROM_DEPTH = 7;
    localparam int WIN_BYTES = 11;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic [7:0] delay_ms;
    } rom_entry_t;

    function automatic rom_entry_t rom_pack(input logic dc, input logic [7:0] data,
                                            input logic [7:0] delay_ms);
        rom_entry_t e;
        e.dc       = dc;
        e.data     = data;
        e.delay_ms = delay_ms;
        return e;
    endfunction

    // Returns {dc, byte} for one position of the CASET/RASET/RAMWR window sequence.
    function automatic logic [8:0] win_entry(input logic [3:0] idx, input logic [15:0] wm1,
                                             input logic [15:0] hm1);
        logic [8:0] e;
        case (idx)
            4'd0:       e = {1'b0, CMD_CASET};
            4'd1, 4'd2: e = {1'b1, 8'h00};
            4'd3:       e = {1'b1, wm1[15:8]};
            4'd4:       e = {1'b1, wm1[7:0]};
            4'd5:       e = {1'b0, CMD_RASET};
            4'd6, 4'd7: e = {1'b1, 8'h00};
            4'd8:       e = {1'b1, hm1[15:8]};
            4'd9:       e = {1'b1, hm1[7:0]};
            default:    e = {1'b0, CMD_RAMWR};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lcd_if.sv
// rtl/lcd_if.sv - pixel source, SPI byte engine and status signals of the LCD sequencer
interface lcd_if;
    logic        frame_start;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        spi_onoff;
    logic [7:0]  spi_data;
    logic        spi_valid;
    logic        dc;
    logic        init_done;
    logic        busy;
    logic        frame_done;

    modport master (
        input  frame_start, pix_data, pix_valid, spi_valid,
        output pix_ready, spi_onoff, spi_data, dc, init_done, busy, frame_done
    );

    modport slave (
        output frame_start, pix_data, pix_valid, spi_valid,
        input  pix_ready, spi_onoff, spi_data, dc, init_done, busy, frame_done
    );
endinterface

// File: rtl/lcd_ms_timer.sv
// rtl/lcd_ms_timer.sv - loadable millisecond countdown with a single-cycle done pulse
module lcd_ms_timer #(
    parameter int unsigned CYC_PER_MS = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_ms,
    output logic       o_done
);
    localparam int DW = $clog2(150 * CYC_PER_MS + 1);

    logic [DW-1:0] r_cnt;

    // Loaded with N-1 and done at count 1, so the caller can act on the edge that
    // completes exactly N cycles after the load request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= DW'(32'(i_ms) * CYC_PER_MS - 32'd1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DW'(1);
        end
    end

    assign o_done = (r_cnt == DW'(1)) && !i_load;

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - SPI LCD sequencer: panel init, address window, RGB565 pixel streaming
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CYC_PER_MS = 100000,
    parameter int unsigned WIDTH      = 240,
    parameter int unsigned HEIGHT     = 320
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    lcd_if.master bus
);
    localparam longint unsigned NPIX = 64'(WIDTH) * 64'(HEIGHT);
    localparam int PCW = $clog2(NPIX + 1);
    localparam logic [15:0] WM1 = 16'(WIDTH - 1);
    localparam logic [15:0] HM1 = 16'(HEIGHT - 1);

    state_t         r_state, w_state;
    logic [2:0]     r_rom_idx, w_rom_idx;
    logic [3:0]     r_win_idx, w_win_idx;
    logic [PCW-1:0] r_pix_cnt, w_pix_cnt;
    logic [15:0]    r_pix, w_pix;
    logic           r_onoff, w_onoff;
    logic [7:0]     r_data, w_data;
    logic           r_dc, w_dc;
    logic           r_init_done, w_init_done;
    logic           r_frame_done, w_frame_done;

    rom_entry_t     w_rom;
    logic [8:0]     w_win;
    logic [7:0]     w_cur_byte;
    logic           w_cur_dc;
    logic           w_send_state;
    logic           w_tmr_load;
    logic           w_tmr_done;

    lcd_ms_timer #(.CYC_PER_MS(CYC_PER_MS)) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (w_tmr_load),
        .i_ms   (w_rom.delay_ms),
        .o_done (w_tmr_done)
    );

    always_comb begin
        w_rom = '0;
        case (r_rom_idx)
            3'd0:    w_rom = rom_pack(1'b0, CMD_SWRESET, 8'd150);
            3'd1:    w_rom = rom_pack(1'b0, CMD_SLPOUT,  8'd120);
            3'd2:    w_rom = rom_pack(1'b0, CMD_COLMOD,  8'd0);
            3'd3:    w_rom = rom_pack(1'b1, 8'h55,       8'd0);
            3'd4:    w_rom = rom_pack(1'b0, CMD_MADCTL,  8'd0);
            3'd5:    w_rom = rom_pack(1'b1, 8'h00,       8'd0);
            3'd6:    w_rom = rom_pack(1'b0, CMD_DISPON,  8'd20);
            default: w_rom = '0;
        endcase
    end

    assign w_win = win_entry(r_win_idx, WM1, HM1);

    always_comb begin
        w_cur_dc   = 1'b1;
        w_cur_byte = r_pix[15:8];
        case (r_state)
            ST_INIT_SEND, ST_INIT_DELAY: begin
                w_cur_dc   = w_rom.dc;
                w_cur_byte = w_rom.data;
            end
            ST_WIN_SEND: {w_cur_dc, w_cur_byte} = w_win;
            ST_PIX_LO:   w_cur_byte = r_pix[7:0];
            default:     ;
        endcase
    end

    assign w_send_state = (r_state == ST_INIT_SEND) || (r_state == ST_WIN_SEND) ||
                          (r_state == ST_PIX_HI)    || (r_state == ST_PIX_LO);

    always_comb begin
        w_state      = r_state;
        w_rom_idx    = r_rom_idx;
        w_win_idx    = r_win_idx;
        w_pix_cnt    = r_pix_cnt;
        w_pix        = r_pix;
        w_onoff      = r_onoff;
        w_data       = r_data;
        w_dc         = r_dc;
        w_init_done  = r_init_done;
        w_frame_done = 1'b0;
        w_tmr_load   = 1'b0;

        if (w_send_state && !r_onoff) begin
            w_onoff = 1'b1;
            w_data  = w_cur_byte;
            w_dc    = w_cur_dc;
        end

        // rom_idx advances when a byte completes, so during INIT_DELAY it already
        // points at the entry to issue once the delay expires.
        case (r_state)
            ST_INIT_SEND: begin
                if (r_onoff && bus.spi_valid) begin
                    w_onoff   = 1'b0;
                    w_rom_idx = r_rom_idx + 3'd1;
                    if (w_rom.delay_ms != 8'd0) begin
                        w_tmr_load = 1'b1;
                        w_state    = ST_INIT_DELAY;
                    end else if (r_rom_idx == 3'(ROM_DEPTH - 1)) begin
                        w_init_done = 1'b1;
                        w_state     = ST_READY;
                    end
                end
            end
            ST_INIT_DELAY: begin
                if (w_tmr_done) begin
                    if (r_rom_idx == 3'(ROM_DEPTH)) begin
                        w_init_done = 1'b1;
                        w_state     = ST_READY;
                    end else begin
                        w_state = ST_INIT_SEND;
                        w_onoff = 1'b1;
                        w_data  = w_cur_byte;
                        w_dc    = w_cur_dc;
                    end
                end
            end
            ST_READY: begin
                if (bus.frame_start && !r_frame_done) begin
                    w_win_idx = 4'd0;
                    w_pix_cnt = PCW'(NPIX);
                    w_state   = ST_WIN_SEND;
                end
            end
            ST_WIN_SEND: begin
                if (r_onoff && bus.spi_valid) begin
                    w_onoff = 1'b0;
                    if (r_win_idx == 4'(WIN_BYTES - 1)) begin
                        w_state = ST_PIX_WAIT;
                    end else begin
                        w_win_idx = r_win_idx + 4'd1;
                    end
                end
            end
            ST_PIX_WAIT: begin
                if (bus.pix_valid) begin
                    w_pix   = bus.pix_data;
                    w_state = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                if (r_onoff && bus.spi_valid) begin
                    w_onoff = 1'b0;
                    w_state = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                if (r_onoff && bus.spi_valid) begin
                    w_onoff   = 1'b0;
                    w_pix_cnt = r_pix_cnt - PCW'(1);
                    if (r_pix_cnt == PCW'(1)) begin
                        w_frame_done = 1'b1;
                        w_state      = ST_READY;
                    end else begin
                        w_state = ST_PIX_WAIT;
                    end
                end
            end
            default: w_state = ST_INIT_SEND;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_INIT_SEND;
            r_rom_idx    <= '0;
            r_win_idx    <= '0;
            r_pix_cnt    <= '0;
            r_pix        <= '0;
            r_onoff      <= 1'b0;
            r_data       <= '0;
            r_dc         <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_rom_idx    <= w_rom_idx;
            r_win_idx    <= w_win_idx;
            r_pix_cnt    <= w_pix_cnt;
            r_pix        <= w_pix;
            r_onoff      <= w_onoff;
            r_data       <= w_data;
            r_dc         <= w_dc;
            r_init_done  <= w_init_done;
            r_frame_done <= w_frame_done;
        end
    end

    assign bus.spi_onoff  = r_onoff;
    assign bus.spi_data   = r_data;
    assign bus.dc         = r_dc;
    assign bus.init_done  = r_init_done;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_state != ST_READY);
    assign bus.pix_ready  = (r_state == ST_PIX_WAIT);

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

- Sequencer for the SPI LCD path; sits between the pixel source and the 8-bit SPI byte engine.
- After reset it plays a fixed panel init sequence (command/parameter bytes with millisecond delays).
- It then streams frames on request: it writes the address window (CASET/RASET/RAMWR) and splits each accepted 16-bit RGB565 pixel into two bytes, MSB first.
- It owns `dc` and the byte-engine handshake; the byte engine itself is unchanged.

## Interface
Parameters:
- CYC_PER_MS, 100000 — clk cycles per millisecond for init delays
- WIDTH, 240 — panel columns (1..65535)
- HEIGHT, 320 — panel rows (1..65535)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (one clock domain, all flops)
- frame_start  input  1  pulse; request one full-frame write
- pix_data  input  16  RGB565 pixel
- pix_valid  input  1  pixel available
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready
- spi_onoff  output  1  byte-engine start; held high until spi_valid
- spi_data  output  8  byte to shift; stable while spi_onoff high
- spi_valid  input  1  1-cycle pulse: current byte fully shifted
- dc  output  1  0 = command byte, 1 = parameter/pixel byte; stable while spi_onoff high
- init_done  output  1  high once init sequence finished; stays high until reset
- busy  output  1  high in every state except READY
- frame_done  output  1  1-cycle pulse after last byte of last pixel

## Operation
- Reset values: spi_onoff=0, spi_data=0x00, dc=0, pix_ready=0, init_done=0, busy=1, frame_done=0. On reset release the FSM enters INIT_SEND.
- States:
  - INIT_SEND: drive ROM entry; on spi_valid go to INIT_DELAY if the entry delay is nonzero, else advance to the next entry.
  - INIT_DELAY: count delay_ms*CYC_PER_MS cycles.
  - READY: idle.
  - WIN_SEND: 11 window bytes.
  - PIX_WAIT, PIX_HI, PIX_LO: pixel streaming.
- Init ROM, in order (byte / dc / delay after):
  - 0x01 / 0 / 150 ms
  - 0x11 / 0 / 120 ms
  - 0x3A / 0 / 0
  - 0x55 / 1 / 0
  - 0x36 / 0 / 0
  - 0x00 / 1 / 0
  - 0x29 / 0 / 20 ms
  After the last delay: init_done=1, go to READY.
- In READY, frame_start=1 loads the window-byte index to 0 and the pixel counter to WIDTH*HEIGHT, then enters WIN_SEND. frame_start is ignored in every other state.
- WIN_SEND bytes (dc per byte):
  - 0x2A(0), 0x00(1), 0x00(1), (WIDTH-1)[15:8](1), (WIDTH-1)[7:0](1)
  - 0x2B(0), 0x00(1), 0x00(1), (HEIGHT-1)[15:8](1), (HEIGHT-1)[7:0](1)
  - 0x2C(0), then PIX_WAIT.
- PIX_WAIT: pix_ready=1. On handshake, latch pix_data and go to PIX_HI (sends [15:8], dc=1), then PIX_LO (sends [7:0], dc=1).
- After PIX_LO's spi_valid, decrement the counter:
  - counter reaches 0: pulse frame_done, go to READY.
  - otherwise: return to PIX_WAIT.
- pix_ready is 0 in all states other than PIX_WAIT. pix_valid without ready is held off with no side effects.
- Pixel counter width is clog2(WIDTH*HEIGHT+1). Delay counter width is clog2(150*CYC_PER_MS+1).

## Timing
- Byte issue: spi_onoff, spi_data and dc are registered. They rise together on the edge after the state is entered.
- On the spi_valid cycle the FSM advances. spi_onoff is 0 for exactly one cycle before the next byte. The minimum byte-to-byte gap is 1 idle cycle.
- spi_valid while spi_onoff=0 is ignored.
- Pixel latency: handshake edge to spi_onoff high with the MSB is 1 cycle.
- Init delay: the first INIT_SEND byte after a delay is issued exactly delay_ms*CYC_PER_MS cycles after the spi_valid that started the delay.
- frame_done asserts on the edge after the final spi_valid, in the same cycle READY is entered. busy drops in that same cycle.
- Reset asserted at any point (mid-byte, mid-delay, mid-frame): all outputs take reset values immediately. Latched pixel and counters are discarded. The full init sequence replays after release.
- frame_start on the same cycle as frame_done (READY not yet reached) is ignored.

## Structure
- lcd_pkg holds:
  - state encoding
  - command opcodes (SWRESET, SLPOUT, COLMOD, MADCTL, DISPON, CASET, RASET, RAMWR)
  - init ROM depth and entry packing: {dc, byte[7:0], delay_ms[7:0]}
- Sub-module lcd_ms_timer: loadable ms countdown with a done pulse, parameterised by CYC_PER_MS.
- The ROM is a combinational case inside lcd_ctrl.

## Test plan
Bench uses CYC_PER_MS=4, WIDTH=4, HEIGHT=2, and an SPI model that pulses spi_valid 8 cycles after spi_onoff rises.
- Release reset → bytes 01,11,3A,55,36,00,29 with dc 0,0,0,1,0,1,0. Gaps of 600 cycles after 0x01 and 480 after 0x11. init_done rises 80 cycles after the 0x29 spi_valid.
- frame_start in READY → bytes 2A,00,00,00,03,2B,00,00,00,01,2C with dc 0,1,1,1,1,0,1,1,1,1,0. Then pix_ready=1.
- 8 pixels 0xF800…0xF807, pix_valid held high → bytes F8,00,…,F8,07, all dc=1. One frame_done pulse, busy=0, pix_ready=0.
- pix_valid low for 50 cycles in PIX_WAIT → spi_onoff stays 0, pix_ready stays 1, counter unchanged.
- reset low during the second pixel's LSB byte → spi_onoff=0, dc=0, init_done=0 asynchronously. After release, 0x01 is resent.
- frame_start during init and mid-frame → no extra window bytes. The frame completes with exactly 8 pixels.
